// File: rtl/lc3b_types.sv
// Shared LC-3b cache types, constants and writeback FSM state encoding.
// Imported by the writeback buffer and its match sub-module.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  localparam int LC3B_LINE_OFFSET_BITS = 4;
  localparam int LC3B_TAG_BITS = 16 - LC3B_LINE_OFFSET_BITS;

  typedef logic [LC3B_TAG_BITS-1:0] lc3b_tag_t;

  typedef enum logic {
    WB_IDLE,
    WB_WRITE
  } lc3b_wb_state_t;

endpackage

// File: rtl/l1_wb_match.sv
// Tag match over buffered lines; reports hit and index of the newest match.
// Scans oldest-to-newest so the entry closest to the tail overrides.
module l1_wb_match
  import lc3b_types::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = 1
) (
  input  lc3b_tag_t        tags_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [PW-1:0]    tail_i,
  input  lc3b_tag_t        tag_i,
  output logic             hit_o,
  output logic [PW-1:0]    idx_o
);

  always_comb begin
    int j;
    logic [PW-1:0] jj;
    hit_o = 1'b0;
    idx_o = '0;
    j     = 0;
    jj    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      j  = (int'(tail_i) + DEPTH - k) % DEPTH;
      jj = PW'(j);
      if (valid_i[jj] && (tags_i[jj] == tag_i)) begin
        hit_o = 1'b1;
        idx_o = jj;
      end
    end
  end

endmodule

// File: rtl/l1_writeback_buffer.sv
// In-order buffer of evicted dirty L1 lines draining to the L2 write port,
// with combinational forwarding of buffered lines to the L1 refill path.
module l1_writeback_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          evict_valid,
  input  lc3b_word      evict_addr,
  input  lc3b_cacheline evict_data,
  output logic          evict_ready,
  input  lc3b_word      lookup_addr,
  output logic          lookup_hit,
  output lc3b_cacheline lookup_data,
  input  logic          l2_grant,
  output logic          l2_write,
  output lc3b_word      l2_address,
  output lc3b_cacheline l2_wdata,
  input  logic          l2_resp,
  output logic          wb_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OB = LC3B_LINE_OFFSET_BITS;

  lc3b_tag_t        tags_q [DEPTH];
  lc3b_cacheline    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  lc3b_wb_state_t   state_q, state_d;

  logic          push, pop;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          unused_lo;

  assign unused_lo = ^{evict_addr[OB-1:0], lookup_addr[OB-1:0]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign evict_ready = (count_q < CW'(DEPTH));
  assign wb_empty    = (count_q == '0);
  assign push        = evict_valid & evict_ready;
  assign pop         = (state_q == WB_WRITE) & l2_resp;

  l1_wb_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .tags_i  (tags_q),
    .valid_i (valid_q),
    .tail_i  (tail_q),
    .tag_i   (lookup_addr[15:OB]),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

  assign lookup_hit  = hit;
  assign lookup_data = hit ? data_q[hit_idx] : '0;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = ptr_inc(tail_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    unique case (state_q)
      WB_IDLE: begin
        if ((count_q != '0) && l2_grant) state_d = WB_WRITE;
      end
      WB_WRITE: begin
        l2_write   = 1'b1;
        l2_address = {tags_q[head_q], {OB{1'b0}}};
        l2_wdata   = data_q[head_q];
        if (l2_resp) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WB_IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tags_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      tags_q[tail_q] <= evict_addr[15:OB];
      data_q[tail_q] <= evict_data;
    end
  end

endmodule

// File: tb/tb_l1_writeback_buffer.sv
// Directed bench for l1_writeback_buffer: per-cycle vector table plus
// hand sequences for pointer wrap, push-during-pop and mid-write reset.
module tb_l1_writeback_buffer;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          evict_valid = 1'b0;
  lc3b_word      evict_addr = '0;
  lc3b_cacheline evict_data = '0;
  logic          evict_ready;
  lc3b_word      lookup_addr = '0;
  logic          lookup_hit;
  lc3b_cacheline lookup_data;
  logic          l2_grant = 1'b0;
  logic          l2_write;
  lc3b_word      l2_address;
  lc3b_cacheline l2_wdata;
  logic          l2_resp = 1'b0;
  logic          wb_empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_writeback_buffer #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .evict_valid (evict_valid),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .evict_ready (evict_ready),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .l2_grant    (l2_grant),
    .l2_write    (l2_write),
    .l2_address  (l2_address),
    .l2_wdata    (l2_wdata),
    .l2_resp     (l2_resp),
    .wb_empty    (wb_empty)
  );

  typedef struct {
    logic          ev;
    logic [15:0]   ea;
    logic [127:0]  ed;
    logic [15:0]   la;
    logic          gr;
    logic          rs;
    logic          x_rdy;
    logic          x_hit;
    logic [127:0]  x_ld;
    logic          x_wr;
    logic [15:0]   x_wa;
    logic [127:0]  x_wd;
    logic          x_emp;
  } vec_t;

  localparam logic [127:0] LA  = 128'hAAAA_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] LX1 = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] LX2 = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] LX3 = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] LB  = 128'hBBBB_BBBB_0000_0000_1234_5678_9ABC_DEF0;
  localparam logic [127:0] LC  = 128'hCCCC_CCCC_FFFF_FFFF_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] LD  = 128'hDDDD_0123_4567_89AB_CDEF_0000_1111_DDDD;
  localparam logic [127:0] LE  = 128'hEEEE_EEEE_EEEE_EEEE_0000_0000_0000_000E;
  localparam logic [127:0] LF  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_000F;
  localparam logic [127:0] LG  = 128'h9999_8888_7777_6666_5555_4444_3333_2222;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic ev, input logic [15:0] ea, input logic [127:0] ed,
    input logic [15:0] la, input logic gr, input logic rs,
    input logic x_rdy, input logic x_hit, input logic [127:0] x_ld,
    input logic x_wr, input logic [15:0] x_wa, input logic [127:0] x_wd,
    input logic x_emp);
    vec_t t;
    t.ev = ev; t.ea = ea; t.ed = ed; t.la = la; t.gr = gr; t.rs = rs;
    t.x_rdy = x_rdy; t.x_hit = x_hit; t.x_ld = x_ld;
    t.x_wr = x_wr; t.x_wa = x_wa; t.x_wd = x_wd; t.x_emp = x_emp;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input int n, input vec_t t);
    string p;
    p = $sformatf("v%0d", n);
    chk({p, ".evict_ready"}, 128'(evict_ready), 128'(t.x_rdy));
    chk({p, ".lookup_hit"},  128'(lookup_hit),  128'(t.x_hit));
    chk({p, ".lookup_data"}, lookup_data,       t.x_ld);
    chk({p, ".l2_write"},    128'(l2_write),    128'(t.x_wr));
    chk({p, ".l2_address"},  128'(l2_address),  128'(t.x_wa));
    chk({p, ".l2_wdata"},    l2_wdata,          t.x_wd);
    chk({p, ".wb_empty"},    128'(wb_empty),    128'(t.x_emp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    #1;
    chk("rst.l2_write",    128'(l2_write),    128'(0));
    chk("rst.wb_empty",    128'(wb_empty),    128'(1));
    chk("rst.evict_ready", 128'(evict_ready), 128'(1));
    chk("rst.lookup_hit",  128'(lookup_hit),  128'(0));
    chk("rst.lookup_data", lookup_data,       128'(0));
    chk("rst.l2_address",  128'(l2_address),  128'(0));
    chk("rst.l2_wdata",    l2_wdata,          128'(0));

    // single push then drain
    tv.push_back(mk(1, 16'h1234, LA, 16'h1230, 1, 0, 1, 0, 0,   0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 16'h1230, 1, 0,         1, 1, LA,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 16'h1230, 0, 0,         1, 1, LA,  1, 16'h1230, LA, 0));
    tv.push_back(mk(0, 0, 0, 16'h1230, 0, 0,         1, 1, LA,  1, 16'h1230, LA, 0));
    tv.push_back(mk(0, 0, 0, 16'h1230, 0, 1,         1, 1, LA,  1, 16'h1230, LA, 0));
    tv.push_back(mk(0, 0, 0, 16'h1230, 0, 0,         1, 0, 0,   0, 0, 0, 1));
    // full and backpressure
    tv.push_back(mk(1, 16'h1000, LX1, 0, 0, 0,       1, 0, 0,   0, 0, 0, 1));
    tv.push_back(mk(1, 16'h2000, LX2, 0, 0, 0,       1, 0, 0,   0, 0, 0, 0));
    tv.push_back(mk(1, 16'h3000, LX3, 0, 0, 0,       0, 0, 0,   0, 0, 0, 0));
    tv.push_back(mk(1, 16'h3000, LX3, 16'h3000, 1, 0, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(mk(1, 16'h3000, LX3, 0, 0, 1,       0, 0, 0,   1, 16'h1000, LX1, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0,                1, 0, 0,   0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 16'h2000, 0, 1,         1, 1, LX2, 1, 16'h2000, LX2, 0));
    tv.push_back(mk(0, 0, 0, 16'h2000, 0, 0,         1, 0, 0,   0, 0, 0, 1));
    // forwarding with duplicate line addresses
    tv.push_back(mk(1, 16'h4000, LB, 16'h400E, 0, 0, 1, 0, 0,   0, 0, 0, 1));
    tv.push_back(mk(1, 16'h4008, LC, 16'h400E, 0, 0, 1, 1, LB,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 16'h400E, 0, 0,         0, 1, LC,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 16'h400E, 1, 0,         0, 1, LC,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 16'h400E, 0, 1,         0, 1, LC,  1, 16'h4000, LB, 0));
    tv.push_back(mk(0, 0, 0, 16'h400E, 1, 0,         1, 1, LC,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 16'h400E, 0, 1,         1, 1, LC,  1, 16'h4000, LC, 0));
    tv.push_back(mk(0, 0, 0, 16'h400E, 0, 0,         1, 0, 0,   0, 0, 0, 1));
    // head in flight stays forwardable, grant ignored while writing
    tv.push_back(mk(1, 16'h5000, LD, 16'h5000, 1, 0, 1, 0, 0,   0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 16'h5000, 1, 0,         1, 1, LD,  0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 16'h5000, 0, 0,         1, 1, LD,  1, 16'h5000, LD, 0));
    tv.push_back(mk(0, 0, 0, 16'h5000, 1, 0,         1, 1, LD,  1, 16'h5000, LD, 0));
    tv.push_back(mk(0, 0, 0, 16'h5000, 0, 1,         1, 1, LD,  1, 16'h5000, LD, 0));
    tv.push_back(mk(0, 0, 0, 16'h5000, 0, 0,         1, 0, 0,   0, 0, 0, 1));

    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < tv.size(); n++) begin
      evict_valid = tv[n].ev;
      evict_addr  = tv[n].ea;
      evict_data  = tv[n].ed;
      lookup_addr = tv[n].la;
      l2_grant    = tv[n].gr;
      l2_resp     = tv[n].rs;
      #1;
      check_vec(n, tv[n]);
      @(negedge clk);
    end
    evict_valid = 1'b0;
    l2_grant    = 1'b0;
    l2_resp     = 1'b0;
    lookup_addr = '0;

    // pointer wrap: five push/drain pairs
    for (int i = 0; i < 5; i++) begin
      evict_valid = 1'b1;
      evict_addr  = 16'h6005 + 16'(i * 16);
      evict_data  = {4{32'hC0DE_0000 + 32'(i)}};
      l2_grant    = 1'b1;
      @(negedge clk);
      evict_valid = 1'b0;
      seen = 1'b0;
      for (int w = 0; w < 4 && !seen; w++) begin
        @(negedge clk);
        #1;
        if (l2_write) seen = 1'b1;
      end
      chk($sformatf("wrap%0d.write_seen", i), 128'(seen), 128'(1));
      chk($sformatf("wrap%0d.addr", i), 128'(l2_address),
          128'(16'h6000 + 16'(i * 16)));
      chk($sformatf("wrap%0d.data", i), l2_wdata,
          {4{32'hC0DE_0000 + 32'(i)}});
      l2_grant = 1'b0;
      l2_resp  = 1'b1;
      @(negedge clk);
      l2_resp = 1'b0;
      #1;
      chk($sformatf("wrap%0d.bubble", i), 128'(l2_write), 128'(0));
      chk($sformatf("wrap%0d.empty", i), 128'(wb_empty), 128'(1));
      @(negedge clk);
    end

    // push in the same cycle the head retires
    evict_valid = 1'b1;
    evict_addr  = 16'h7000;
    evict_data  = LE;
    l2_grant    = 1'b1;
    @(negedge clk);
    evict_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pp.write", 128'(l2_write), 128'(1));
    chk("pp.addr", 128'(l2_address), 128'(16'h7000));
    evict_valid = 1'b1;
    evict_addr  = 16'h7100;
    evict_data  = LF;
    l2_resp     = 1'b1;
    l2_grant    = 1'b0;
    #1;
    chk("pp.ready", 128'(evict_ready), 128'(1));
    @(negedge clk);
    evict_valid = 1'b0;
    l2_resp     = 1'b0;
    lookup_addr = 16'h7100;
    #1;
    chk("pp.empty", 128'(wb_empty), 128'(0));
    chk("pp.bubble", 128'(l2_write), 128'(0));
    chk("pp.hit_new", 128'(lookup_hit), 128'(1));
    chk("pp.data_new", lookup_data, LF);
    lookup_addr = 16'h7000;
    #1;
    chk("pp.hit_old", 128'(lookup_hit), 128'(0));
    l2_grant = 1'b1;
    @(negedge clk);
    l2_grant = 1'b0;
    #1;
    chk("pp.write2", 128'(l2_write), 128'(1));
    chk("pp.addr2", 128'(l2_address), 128'(16'h7100));
    chk("pp.data2", l2_wdata, LF);
    l2_resp = 1'b1;
    @(negedge clk);
    l2_resp = 1'b0;
    #1;
    chk("pp.empty2", 128'(wb_empty), 128'(1));

    // asynchronous reset during a write
    @(negedge clk);
    evict_valid = 1'b1;
    evict_addr  = 16'h8000;
    evict_data  = LG;
    l2_grant    = 1'b1;
    @(negedge clk);
    evict_valid = 1'b0;
    @(negedge clk);
    l2_grant    = 1'b0;
    lookup_addr = 16'h8000;
    #1;
    chk("ar.write_before", 128'(l2_write), 128'(1));
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar.write", 128'(l2_write), 128'(0));
    chk("ar.empty", 128'(wb_empty), 128'(1));
    chk("ar.ready", 128'(evict_ready), 128'(1));
    chk("ar.hit", 128'(lookup_hit), 128'(0));
    chk("ar.addr", 128'(l2_address), 128'(0));
    @(negedge clk);
    reset_n  = 1'b1;
    l2_grant = 1'b1;
    @(negedge clk);
    #1;
    chk("ar.write_after", 128'(l2_write), 128'(0));
    chk("ar.empty_after", 128'(wb_empty), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
